// File: rtl/prewitt_pkg.sv
// Shared constants and types for the Prewitt window controller: state
// encoding, default geometry and the delayed-result slot record.
package prewitt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FILL = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int DEF_WIDTH      = 24;
  localparam int DEF_PIC_WIDTH  = 320;
  localparam int DEF_PIC_HEIGHT = 240;
  localparam int DEF_MAT_LAT    = 1;

  // Gray channel of an RGB888 pixel.
  localparam int GRAY_MSB = 7;
  localparam int GRAY_LSB = 0;
  typedef logic [GRAY_MSB:GRAY_LSB] gray_t;

  typedef struct packed {
    logic valid;
    logic border;
  } slot_t;

endpackage

// File: rtl/prewitt_line_buf.sv
// One line of pixel storage: simple dual-port RAM, registered read,
// read-before-write on a same-address collision.
module prewitt_line_buf
  import prewitt_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_PIC_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto block RAM; every location is rewritten before it is ever used.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prewitt_window_ctrl.sv
// Frame/row/column sequencer feeding the 3x3 Prewitt window datapath.
// Optional build macro PREWITT_CTRL_SOF_ERR_EN: mid-frame frame_start flags err_o and restarts.
module prewitt_window_ctrl
  import prewitt_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int MAT_LAT    = DEF_MAT_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] din1,
  output logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] din3,
  output logic             win_valid,
  output logic             m_valid,
  output logic             border,
  output logic             busy,
  output logic             frame_done,
  output logic             err_o
);

  localparam int CW  = $clog2(PIC_WIDTH);
  localparam int RW  = $clog2(PIC_HEIGHT);
  localparam int DLY = MAT_LAT + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, lb_wcol_q;
  logic [RW-1:0]    row_q, row_d;
  logic             accept, restart, col_last, win_d;
  logic             lb_we_q, win_valid_q, win_border_q;
  logic [WIDTH-1:0] din3_q, din2_hold_q, din1_hold_q;
  logic [WIDTH-1:0] lb0_rdata, lb1_rdata;
  slot_t            dly_q [DLY];

  assign accept   = s_valid && s_ready;
  assign col_last = (col_q == COL_LAST);
  assign win_d    = accept && (row_q >= RW'(2));

`ifdef PREWITT_CTRL_SOF_ERR_EN
  logic err_q;
  assign restart = frame_start && ((state_q == FILL) || (state_q == RUN));
  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (restart) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign restart = 1'b0;
  assign err_o   = 1'b0;
`endif

  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (frame_start) state_d = FILL;
      FILL: if (restart) state_d = FILL;
            else if (accept && col_last && (row_q == RW'(1))) state_d = RUN;
      RUN:  if (restart) state_d = FILL;
            else if (accept && col_last && (row_q == ROW_LAST)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart || ((state_q == IDLE) && frame_start)) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE:      busy       = 1'b0;
      FILL, RUN: s_ready    = !restart;
      DONE:      frame_done = 1'b1;
      default:   busy       = 1'b0;
    endcase
  end

  // lb1 takes the displaced lb0 word one cycle later, once the lb0 read has landed.
  prewitt_line_buf #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (s_data),
    .re_i    (accept),
    .raddr_i (col_q),
    .rdata_o (lb0_rdata)
  );

  prewitt_line_buf #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_lb1 (
    .clk     (clk),
    .we_i    (lb_we_q),
    .waddr_i (lb_wcol_q),
    .wdata_i (lb0_rdata),
    .re_i    (accept),
    .raddr_i (col_q),
    .rdata_o (lb1_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_we_q      <= 1'b0;
      lb_wcol_q    <= '0;
      win_valid_q  <= 1'b0;
      win_border_q <= 1'b0;
      din3_q       <= '0;
      din2_hold_q  <= '0;
      din1_hold_q  <= '0;
    end else begin
      lb_we_q     <= accept;
      lb_wcol_q   <= col_q;
      win_valid_q <= win_d;
      if (win_d) begin
        din3_q       <= s_data;
        win_border_q <= (col_q < CW'(2));
      end
      if (win_valid_q) begin
        din2_hold_q <= lb0_rdata;
        din1_hold_q <= lb1_rdata;
      end
    end
  end

  assign win_valid = win_valid_q;
  assign din3      = din3_q;
  assign din2      = win_valid_q ? lb0_rdata : din2_hold_q;
  assign din1      = win_valid_q ? lb1_rdata : din1_hold_q;

  // Cycle-based delay that lines the flags up with the matrix result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= slot_t'{valid: win_valid_q, border: win_border_q};
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign m_valid = dly_q[DLY-1].valid & ~dly_q[DLY-1].border;
  assign border  = dly_q[DLY-1].valid &  dly_q[DLY-1].border;

endmodule

// File: tb/tb_prewitt_window_ctrl.sv
// Directed bench for prewitt_window_ctrl on an 8x4 frame: scenario table plus
// hand-written reset and mid-frame frame_start sequences.
module tb_prewitt_window_ctrl;

  localparam int WIDTH = 24;
  localparam int PW    = 8;
  localparam int PH    = 4;
  localparam int ML    = 1;
  localparam int NPIX  = PW * PH;
  localparam int NWIN  = PW * (PH - 2);
  localparam int DLY   = ML + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready, win_valid, m_valid, border, busy, frame_done, err_o;
  logic [WIDTH-1:0] din1, din2, din3;

  prewitt_window_ctrl #(.WIDTH(WIDTH), .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .MAT_LAT(ML)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .din1        (din1),
    .din2        (din2),
    .din3        (din3),
    .win_valid   (win_valid),
    .m_valid     (m_valid),
    .border      (border),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard state
  logic [71:0] win_log [64];
  int          win_cyc [64];
  int          acc_edge [128];
  int          done_cyc [4];
  int n_win, n_acc, n_done, n_mval, n_border;
  int hold_viol, dl_err, ready_in_done, busy_after_done, first_border_cyc;
  logic [71:0] last_taps = '0;
  logic        pipe_v [DLY] = '{default: 1'b0};
  logic        pipe_b [DLY] = '{default: 1'b0};
  int          wcol = 0;
  logic        prev_done = 1'b0;
  int          px_idx = 0;

  task automatic clear_mon();
    n_win = 0; n_acc = 0; n_done = 0; n_mval = 0; n_border = 0;
    hold_viol = 0; dl_err = 0; ready_in_done = 0; busy_after_done = 0;
    first_border_cyc = -1;
    for (int i = 0; i < 64; i++) begin win_log[i] = '1; win_cyc[i] = -1; end
    for (int i = 0; i < 4; i++) done_cyc[i] = -1;
  endtask

  always @(negedge clk) begin
    logic [71:0] taps;
    taps = {din1, din2, din3};
    if (m_valid !== (pipe_v[DLY-1] && !pipe_b[DLY-1]) ||
        border  !== (pipe_v[DLY-1] &&  pipe_b[DLY-1])) dl_err++;
    if (m_valid) n_mval++;
    if (border) begin
      n_border++;
      if (first_border_cyc < 0) first_border_cyc = cyc;
    end
    if (frame_done) begin
      if (n_done < 4) done_cyc[n_done] = cyc;
      n_done++;
      if (s_ready) ready_in_done++;
    end
    if (prev_done && busy) busy_after_done++;
    prev_done = frame_done;
    if (win_valid) begin
      if (n_win < 64) begin win_log[n_win] = taps; win_cyc[n_win] = cyc; end
      n_win++;
      last_taps = taps;
    end else if (taps !== last_taps) begin
      hold_viol++;
    end
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) begin pipe_v[i] = 1'b0; pipe_b[i] = 1'b0; end
      last_taps = '0;
      wcol      = 0;
      prev_done = 1'b0;
    end else begin
      for (int i = DLY - 1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_b[i] = pipe_b[i-1]; end
      pipe_v[0] = win_valid;
      pipe_b[0] = win_valid && (wcol < 2);
      if (win_valid) wcol = (wcol + 1) % PW;
    end
  end

  function automatic logic [WIDTH-1:0] pix(input int idx);
    return WIDTH'((idx / PW) * 16 + idx % PW);
  endfunction

  function automatic logic [71:0] exp_taps(input int w);
    int k, r, c;
    k = w % NWIN;
    r = 2 + k / PW;
    c = k % PW;
    return {pix((r - 2) * PW + c), pix((r - 1) * PW + c), pix(r * PW + c)};
  endfunction

  // Entered and left at posedge+1.
  task automatic step_pixel(input int gap_pct);
    s_valid = ($urandom_range(99) >= gap_pct);
    s_data  = pix(px_idx);
    @(negedge clk);
    if (s_valid && s_ready) begin
      if (n_acc < 128) acc_edge[n_acc] = cyc + 1;
      n_acc++;
      px_idx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_pixels(input int gap_pct, input int n_stop);
    int budget;
    budget = 2000;
    while (px_idx < n_stop && budget > 0) begin
      step_pixel(gap_pct);
      budget--;
    end
    s_valid = 1'b0;
    check("pixels_accepted", px_idx, n_stop);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    s_valid     = 1'b1;
    s_data      = pix(0);
    px_idx      = 0;
    @(negedge clk);
    check("sof_cycle_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    s_valid     = 1'b0;
  endtask

  task automatic check_frames(input string nm, input int nfr, input int ew, input int em,
                              input int eb, input int ed);
    int t_err;
    check({nm, " win_count"}, n_win, ew);
    check({nm, " mvalid_count"}, n_mval, em);
    check({nm, " border_count"}, n_border, eb);
    check({nm, " done_count"}, n_done, ed);
    for (int w = 0; w < ew; w++)
      check($sformatf("%s taps[%0d]", nm, w), win_log[w], exp_taps(w));
    t_err = 0;
    for (int w = 0; w < ew; w++)
      if (win_cyc[w] != acc_edge[(w / NWIN) * NPIX + 2 * PW + w % NWIN]) t_err++;
    check({nm, " win_timing_errs"}, t_err, 0);
    check({nm, " first_win_cyc"}, win_cyc[0], acc_edge[2 * PW]);
    check({nm, " first_border_cyc"}, first_border_cyc, win_cyc[0] + DLY);
    for (int f = 0; f < nfr; f++)
      check($sformatf("%s done_cyc[%0d]", nm, f), done_cyc[f], acc_edge[f * NPIX + NPIX - 1]);
    check({nm, " mvalid_border_align_errs"}, dl_err, 0);
    check({nm, " tap_hold_errs"}, hold_viol, 0);
    check({nm, " ready_in_done"}, ready_in_done, 0);
    check({nm, " busy_after_done"}, busy_after_done, 0);
  endtask

  typedef struct {
    string name;
    int    gap_pct;
    int    nframes;
    int    exp_win;
    int    exp_mval;
    int    exp_border;
    int    exp_done;
  } vec_t;

  vec_t vecs [3];

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int exp_err;
    vecs[0] = '{name: "cont",  gap_pct: 0,  nframes: 1, exp_win: 16, exp_mval: 12, exp_border: 4, exp_done: 1};
    vecs[1] = '{name: "gap50", gap_pct: 50, nframes: 1, exp_win: 16, exp_mval: 12, exp_border: 4, exp_done: 1};
    vecs[2] = '{name: "b2b",   gap_pct: 0,  nframes: 2, exp_win: 32, exp_mval: 24, exp_border: 8, exp_done: 2};
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {s_ready, din1, din2, din3, win_valid, m_valid, border, busy, frame_done, err_o}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: pixels offered without frame_start are never taken
    bad = 0;
    s_valid = 1'b1;
    s_data  = 24'h123456;
    repeat (20) begin
      @(negedge clk);
      if (s_ready || busy || win_valid) bad++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("idle_no_activity", bad, 0);

    // Table-driven frame scenarios
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      for (int f = 0; f < vecs[v].nframes; f++) begin
        if (f == 0) begin
          repeat (3) @(posedge clk);
          #1;
        end else begin
          @(posedge clk); #1;
        end
        start_frame();
        run_pixels(vecs[v].gap_pct, NPIX);
      end
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("%s busy_end", vecs[v].name), busy, 1'b0);
      check_frames(vecs[v].name, vecs[v].nframes, vecs[v].exp_win, vecs[v].exp_mval,
                   vecs[v].exp_border, vecs[v].exp_done);
    end
    check("first_taps_literal", vecs[0].exp_win > 0 ? exp_taps(0) : '0, 72'h000000_000010_000020);

    // Reset at row 2, col 3
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    start_frame();
    run_pixels(0, 2 * PW + 3);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_outputs", {s_ready, din1, din2, din3, win_valid, m_valid, border, busy, frame_done, err_o}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_done", n_done, 0);
    check("midreset_idle", busy, 1'b0);
    clear_mon();
    start_frame();
    run_pixels(0, NPIX);
    repeat (8) @(posedge clk);
    #1;
    check_frames("after_reset", 1, NWIN, 12, 4, 1);

    // frame_start at row 1, col 5
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    start_frame();
    run_pixels(0, PW + 5);
    frame_start = 1'b1;
    s_valid     = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
`ifdef PREWITT_CTRL_SOF_ERR_EN
    exp_err = 1;
    px_idx  = 0;
    clear_mon();
`else
    exp_err = 0;
`endif
    run_pixels(0, NPIX);
    repeat (8) @(posedge clk);
    #1;
    check("sof_mid_err_o", err_o, exp_err[0]);
    check_frames("sof_mid", 1, NWIN, 12, 4, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/prewitt_window_ctrl.md
Name: prewitt_window_ctrl

Overview:
- Sequences a pixel stream into the 3x3 window datapath of the Prewitt edge pipeline.
- Owns frame/row/column counting and two internal line buffers.
- Drives the three row taps and the per-pixel valid strobe into the matrix block.
- Produces an output-valid/border flag aligned to the matrix block's result, plus frame-done status.

Parameters:
- WIDTH, 24, pixel width in bits (RGB888; gray in [7:0]).
- PIC_WIDTH, 320, pixels per line (>=3).
- PIC_HEIGHT, 240, lines per frame (>=3).
- MAT_LAT, 1, cycles from win_valid to the matrix result register update.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse; arms a new frame.
- s_valid  in  1  input pixel valid.
- s_data  in  WIDTH  input pixel.
- s_ready  out  1  pixel accepted when s_valid && s_ready.
- din1  out  WIDTH  tap, row r-2 (oldest).
- din2  out  WIDTH  tap, row r-1.
- din3  out  WIDTH  tap, row r (current).
- win_valid  out  1  taps valid; drives matrix valid_in.
- m_valid  out  1  matrix result valid for an interior pixel.
- border  out  1  with m_valid timing: column <2 (left border, result invalid).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel.
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at clk edge) clears all outputs, counters and the state to IDLE. Line-buffer RAM contents are not cleared. Reset mid-frame aborts the frame with no frame_done.
- FSM states:
  - IDLE: s_ready=0. frame_start -> FILL. A pixel presented in the frame_start cycle is not accepted.
  - FILL: s_ready=1. Rows 0..1; pixels are written to the line buffers and win_valid stays 0. After the last pixel of row 1 -> RUN.
  - RUN: s_ready=1. Rows 2..PIC_HEIGHT-1. After the last pixel of row PIC_HEIGHT-1 -> DONE.
  - DONE: s_ready=0 for exactly one cycle; frame_done=1; -> IDLE.
- Counters:
  - col counts 0..PIC_WIDTH-1; row counts 0..PIC_HEIGHT-1.
  - Widths are $clog2 of the respective parameter.
  - Both advance only on accept. col wraps to 0 and row increments on accept with col==PIC_WIDTH-1.
- Line buffers:
  - lb0 holds row r-1, lb1 holds row r-2.
  - On each accept at column c: read lb0[c] and lb1[c]; write s_data to lb0[c]; write the old lb0[c] to lb1[c].
  - Read-before-write, 1-cycle read latency.
- Taps and win_valid:
  - din3/din2/din1 = registered s_data / lb0[c] / lb1[c].
  - All become valid 1 cycle after the accept; win_valid=1 in that cycle iff the accept occurred with row>=2. Otherwise 0.
  - When win_valid=0, taps hold their previous values.
- Output alignment:
  - m_valid = win_valid delayed MAT_LAT+2 cycles (window column fill), gated to the interior.
  - border = 1 for the delayed slots at col<2; m_valid=0 for those slots.
  - The delay line is a shift register that advances every cycle and is cleared by reset.
- Stalls: s_valid=0 inserts bubbles; counters and taps hold. No data is lost.
- err_o resets to 0.

Optional Feature:
- Macro: PREWITT_CTRL_SOF_ERR_EN.
- Defined:
  - frame_start while state is FILL or RUN sets err_o (sticky until reset) and restarts the frame: counters -> 0, state -> FILL.
  - frame_start in DONE is ignored.
- Undefined:
  - frame_start outside IDLE is ignored; err_o is tied to 0.

Decomposition:
- Shared package prewitt_pkg:
  - state encoding localparams (IDLE=0, FILL=1, RUN=2, DONE=3);
  - default WIDTH/PIC_WIDTH/PIC_HEIGHT constants;
  - gray-slice constant [7:0].
- One sub-module, prewitt_line_buf:
  - single-clock simple dual-port RAM, depth PIC_WIDTH, WIDTH bits;
  - 1-cycle registered read, read-before-write;
  - instantiated twice.

Test Plan (PIC_WIDTH=8, PIC_HEIGHT=4, MAT_LAT=1):
- Reset + idle: s_valid=1 without frame_start for 20 cycles -> s_ready=0, busy=0, no win_valid.
- Full frame, pixel value = row*16+col, continuous valid -> 16 win_valid pulses.
  - First one at the cycle after accept (row 2, col 0), with din1=0x00, din2=0x10, din3=0x20.
  - 12 m_valid, 4 border slots, frame_done one cycle after the 32nd accept, then busy=0.
- Random s_valid gaps (50%) on the same frame -> identical tap sequence and counts to the continuous run; taps hold during gaps.
- Back-to-back frames with frame_start in the DONE+1 cycle -> second frame identical to the first; no lost pixels.
- Reset asserted at row 2, col 3 -> next cycle all outputs 0, state IDLE, no frame_done.
  - A new frame afterwards matches the golden model.
- frame_start at row 1, col 5:
  - with PREWITT_CTRL_SOF_ERR_EN: err_o=1 and restart (next accept is row 0, col 0);
  - without it: err_o=0 and the frame completes normally.
